gamecube_command_sender: RTL
============================

Name: gamecube_command_sender

Overview:
- Sequences the Gamecube bit transmitter to send a whole console command: 1..MAX_BYTES bytes, MSB first, then one stop bit '1'.
- Drives the transmitter's n_SEND/TX inputs on a self-timed 4-cycle bit slot, so bits go out back-to-back.
- Watches the transmitter's BUSY to detect loss of lock.
- Sits between the command/poll logic and the bit transmitter; all ports are in the 1 MHz CLK domain.

Parameters:
- MAX_BYTES, 3, maximum command length in bytes (3 covers the 0x400302 poll command).
- LEN_W, 2, width of LEN; must satisfy 2**LEN_W > MAX_BYTES.

Ports:
- CLK  input  1  1 MHz system clock, rising edge active.
- n_RST  input  1  reset; asynchronous, active-low.
- START  input  1  request to send; sampled on CLK rising edge.
- LEN  input  LEN_W  byte count; captured with START.
- CMD  input  8*MAX_BYTES  command bytes; captured with START. Byte 0 = CMD[8*MAX_BYTES-1 -: 8].
- BUSY  input  1  BUSY output of the bit transmitter.
- n_SEND  output  1  to transmitter n_SEND; registered.
- TX  output  1  to transmitter TX; registered.
- ACTIVE  output  1  high while a command is in progress.
- DONE  output  1  one-cycle pulse when a command has completed.
- REJECT  output  1  one-cycle pulse when START is refused.
- FAULT  output  1  one-cycle pulse on a transmitter handshake fault.

Behaviour:
- Reset (async, n_RST=0):
  - State is IDLE.
  - n_SEND=1, TX=1, ACTIVE=0, DONE=0, REJECT=0, FAULT=0.
  - Phase counter=0, bit counter=0.
  - Release of reset takes effect on the next rising edge.
- States: IDLE, SEND, DRAIN. All outputs are registered.
- IDLE, rising edge with START=1:
  - If LEN==0 or LEN>MAX_BYTES: REJECT=1 for one cycle; stay in IDLE.
  - Otherwise, at this edge (E0):
    - Load shift register with CMD.
    - Total bits NB = 8*LEN+1 (the last is the stop bit '1').
    - TX <= first bit (CMD MSB), n_SEND <= 0, phase <= 0, ACTIVE <= 1.
    - Go to SEND.
- START while ACTIVE=1 is ignored: no REJECT, no effect.
- SEND:
  - Phase increments mod 4 on every edge. The transmitter captures bit k at edge E(1+4k).
  - Edge where current phase==3:
    - If bits remain: TX <= next bit and the bit counter advances. The shift is MSB first; after the last data bit TX=1 for the stop bit.
    - After the last bit (stop bit) slot: n_SEND <= 1, TX <= 1, go to DRAIN. This is edge E(4*NB).
  - Edge where current phase==2: BUSY must be 1. If BUSY=0:
    - n_SEND <= 1, TX <= 1, FAULT=1 for one cycle, ACTIVE <= 0, go to IDLE.
    - No DONE is issued.
- DRAIN:
  - Lasts one cycle; the transmitter returns to idle on this edge.
  - Next edge E(4*NB+1): ACTIVE <= 0, DONE <= 1 for one cycle, go to IDLE.
- Latency: START accepted at E0 → DONE visible after E(4*NB+1).
  - 1-byte command (NB=9): DONE after E37.
  - 3-byte command (NB=25): DONE after E101.
- A new START is accepted on the same edge where DONE is asserted (state is already IDLE).
- Reset mid-operation:
  - Outputs return immediately to reset values; n_SEND goes high asynchronously.
  - No DONE or FAULT pulse.
  - The transmitter finishes its current bit on its own.
- CMD/LEN changes after acceptance have no effect.

Test Plan:
- Reset during idle, then START with LEN=1, CMD[23:16]=0x00 → TX presents 0,0,0,0,0,0,0,0,1, each held 4 cycles. n_SEND low E0..E36. DONE pulse after E37. DATALINE shows 9 encoded bits with no gaps.
- START with LEN=3, CMD=0x400302 → 25 bits: 0100_0000_0000_0011_0000_0010 then 1. ACTIVE high 101 cycles. DONE after E101.
- START with LEN=0, and separately LEN=3 with MAX_BYTES=2 → REJECT one cycle; n_SEND stays 1; no DONE.
- Transmitter BUSY forced to 0 during bit 3 → FAULT pulse at phase-2 edge of that bit; n_SEND=1 next cycle; ACTIVE=0; no DONE.
- Assert n_RST low at bit 10 of a 3-byte command → n_SEND=1, ACTIVE=0 immediately. After release, a new START with LEN=1 completes normally in 37 cycles.
- START held high continuously with LEN=1 → back-to-back commands; each DONE followed by acceptance on the same edge; START during ACTIVE ignored.

Source files
------------

// File: rtl/gamecube_command_sender.sv
// Sequences the Gamecube bit transmitter through a whole console command:
// LEN bytes MSB first plus a trailing stop bit, one bit per 4-cycle slot.
module gamecube_command_sender #(
  parameter int MAX_BYTES = 3,
  parameter int LEN_W     = 2
) (
  input  logic                   CLK,
  input  logic                   n_RST,
  input  logic                   START,
  input  logic [LEN_W-1:0]       LEN,
  input  logic [8*MAX_BYTES-1:0] CMD,
  input  logic                   BUSY,
  output logic                   n_SEND,
  output logic                   TX,
  output logic                   ACTIVE,
  output logic                   DONE,
  output logic                   REJECT,
  output logic                   FAULT
);

  localparam int CMD_W = 8 * MAX_BYTES;
  localparam int CNT_W = $clog2(CMD_W + 2);
  localparam logic [LEN_W:0]   MAX_LEN = (LEN_W + 1)'(MAX_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [1:0]       phase_r, phase_s;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
  logic [CNT_W-1:0] last_bit_r, last_bit_s;
  logic [CMD_W-1:0] shift_r, shift_s;
  logic             n_send_r, n_send_s;
  logic             tx_r, tx_s;
  logic             active_r, active_s;
  logic             done_r, done_s;
  logic             reject_r, reject_s;
  logic             fault_r, fault_s;
  logic             len_bad_s;

  assign len_bad_s = (LEN == {LEN_W{1'b0}}) || ({1'b0, LEN} > MAX_LEN);

  // State and output registers
  always_ff @(posedge CLK or negedge n_RST) begin
    if (!n_RST) begin
      state_r    <= IDLE;
      phase_r    <= 2'd0;
      bit_cnt_r  <= {CNT_W{1'b0}};
      last_bit_r <= {CNT_W{1'b0}};
      shift_r    <= {CMD_W{1'b0}};
      n_send_r   <= 1'b1;
      tx_r       <= 1'b1;
      active_r   <= 1'b0;
      done_r     <= 1'b0;
      reject_r   <= 1'b0;
      fault_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      phase_r    <= phase_s;
      bit_cnt_r  <= bit_cnt_s;
      last_bit_r <= last_bit_s;
      shift_r    <= shift_s;
      n_send_r   <= n_send_s;
      tx_r       <= tx_s;
      active_r   <= active_s;
      done_r     <= done_s;
      reject_r   <= reject_s;
      fault_r    <= fault_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s    = state_r;
    phase_s    = phase_r;
    bit_cnt_s  = bit_cnt_r;
    last_bit_s = last_bit_r;
    shift_s    = shift_r;
    n_send_s   = n_send_r;
    tx_s       = tx_r;
    active_s   = active_r;
    done_s     = 1'b0;
    reject_s   = 1'b0;
    fault_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (START) begin
          if (len_bad_s) begin
            reject_s = 1'b1;
          end else begin
            state_s    = SEND;
            phase_s    = 2'd0;
            bit_cnt_s  = {CNT_W{1'b0}};
            // index of the stop bit, i.e. 8*LEN
            last_bit_s = CNT_W'({LEN, 3'b000});
            shift_s    = CMD;
            tx_s       = CMD[CMD_W-1];
            n_send_s   = 1'b0;
            active_s   = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end

      SEND: begin
        phase_s = phase_r + 2'd1;
        case (phase_r)
          2'd2: begin
            if (!BUSY) begin
              state_s   = IDLE;
              phase_s   = 2'd0;
              bit_cnt_s = {CNT_W{1'b0}};
              n_send_s  = 1'b1;
              tx_s      = 1'b1;
              active_s  = 1'b0;
              fault_s   = 1'b1;
            end else begin
              state_s = SEND;
            end
          end
          2'd3: begin
            if (bit_cnt_r == last_bit_r) begin
              state_s   = DRAIN;
              phase_s   = 2'd0;
              bit_cnt_s = {CNT_W{1'b0}};
              n_send_s  = 1'b1;
              tx_s      = 1'b1;
            end else begin
              bit_cnt_s = bit_cnt_r + CNT_ONE;
              shift_s   = {shift_r[CMD_W-2:0], 1'b1};
              // shift register may still hold unused trailing bytes, so force the stop bit
              tx_s      = (bit_cnt_s == last_bit_r) ? 1'b1 : shift_r[CMD_W-2];
            end
          end
          default: begin
            state_s = SEND;
          end
        endcase
      end

      DRAIN: begin
        state_s  = IDLE;
        active_s = 1'b0;
        done_s   = 1'b1;
      end

      default: begin
        state_s   = IDLE;
        phase_s   = 2'd0;
        bit_cnt_s = {CNT_W{1'b0}};
        n_send_s  = 1'b1;
        tx_s      = 1'b1;
        active_s  = 1'b0;
      end
    endcase
  end

  assign n_SEND = n_send_r;
  assign TX     = tx_r;
  assign ACTIVE = active_r;
  assign DONE   = done_r;
  assign REJECT = reject_r;
  assign FAULT  = fault_r;

endmodule
